ssp_tx_fifo: RTL and testbench
==============================

# ssp_tx_fifo

Transmit FIFO sitting between the processor write port and the SSP serializer (`ssp_tx_rx`). It buffers up to DEPTH bytes written by the processor and presents them first-word-fall-through to the serializer. The serializer pops a word with a one-cycle `TxNextWord` strobe. The block flags a full condition to the processor as `SSPTXINTR`.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 4, number of storage words; must be a power of two, at least 2.
- `AW`, 2, pointer width; equals log2(DEPTH).

- `PCLK` in 1: system clock; all state changes on the rising edge.
- `CLEAR` in 1: synchronous active-high reset. One clock; reset is synchronous and active-high.
- `PSEL` in 1: processor selects the SSP.
- `PWRITE` in 1: processor write strobe; a push request is `PSEL && PWRITE`.
- `PWDATA` in WIDTH: processor write data.
- `TxNextWord` in 1: serializer pop strobe, one PCLK wide.
- `TxData` out WIDTH: head-of-queue word (fall-through).
- `TxValidWord` out 1: head word is valid (not empty).
- `TxIsEmpty` out 1: FIFO holds zero words.
- `SSPTXINTR` out 1: FIFO full; the processor must not write.
- `TxCount` out AW+1: number of words currently stored, 0..DEPTH.

## Operation
- Storage is a DEPTH×WIDTH register array, a write pointer `wp`, a read pointer `rp` (both AW bits, wrap modulo DEPTH), and a count `cnt` (AW+1 bits).
- Push accepted (`do_wr`) = `PSEL && PWRITE && (cnt != DEPTH || do_rd)`.
  - On `do_wr`: `mem[wp] <= PWDATA`, `wp <= wp+1`.
- Pop accepted (`do_rd`) = `TxNextWord && cnt != 0`.
  - On `do_rd`: `rp <= rp+1`.
- Count update:
  - `do_wr` only: `cnt+1`.
  - `do_rd` only: `cnt-1`.
  - Both or neither: unchanged.
- Push while full with no simultaneous pop: silently dropped. Memory, `wp` and `cnt` are unchanged.
- Pop while empty: ignored. `rp` and `cnt` are unchanged.
- Simultaneous push and pop when empty: the pop is ignored and the push lands, so `cnt` goes 0→1.
- Simultaneous push and pop when full: both are accepted and `cnt` stays DEPTH. The written slot is the one being vacated: `wp == rp` at that point, and the read takes the old value.
- Outputs:
  - `TxData = mem[rp]`, combinational from registers.
  - `TxValidWord = (cnt != 0)`.
  - `TxIsEmpty = (cnt == 0)`.
  - `SSPTXINTR = (cnt == DEPTH)`.
  - `TxCount = cnt`.
  - All outputs are derived only from registered state; there is no combinational path from any input to any output.

## Timing
- Reset, when `CLEAR` is high at an edge:
  - `wp`, `rp` and `cnt` go to 0 and all `mem` words go to 0.
  - After that edge: `TxData=0`, `TxValidWord=0`, `TxIsEmpty=1`, `SSPTXINTR=0`, `TxCount=0`.
  - Reset overrides any same-cycle push or pop.
  - A reset mid-stream discards all queued words.
- Push latency: a word pushed at edge N is visible on `TxData` (when the FIFO was empty) and `TxValidWord` goes high after edge N.
- Pop: the serializer samples `TxData` in the same cycle it asserts `TxNextWord`. After that edge `TxData` shows the next word, or a stale value with `TxValidWord=0`.
- `SSPTXINTR` asserts after the edge that makes `cnt==DEPTH` and deasserts after the first pop edge.
- Throughput: one push and one pop per PCLK, sustained.

## Test plan
- Reset then idle → `TxIsEmpty=1`, `TxValidWord=0`, `SSPTXINTR=0`, `TxCount=0`, `TxData=8'h00`.
- Push 8'hA5 → next cycle `TxData=8'hA5`, `TxValidWord=1`, `TxCount=1`. Pulse `TxNextWord` → `TxIsEmpty=1`, `TxCount=0`.
- Overflow:
  - Push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 on consecutive cycles → `SSPTXINTR=1` after the 4th push and `TxCount=4`.
  - 8'h55 is dropped.
  - Four pops return 11, 22, 33, 44, then `TxIsEmpty=1`.
- Pop on empty: `TxNextWord` asserted for 3 cycles with the FIFO empty → `rp` and `cnt` are unchanged. A subsequent push of 8'h7E is read back correctly.
- Simultaneous push and pop:
  - When full (holding 11..44) with push 8'h99 → `TxCount` stays 4 and the popped word is 11.
  - The remaining order is 22, 33, 44, 99.
  - When empty with push 8'hC3 → `TxCount=1` and `TxData=8'hC3`.
- Wrap and reset:
  - Stream 10 words, 8'h01..8'h0A, with interleaved pops → data order is preserved across pointer wrap.
  - Asserting `CLEAR` with 3 words queued returns all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/ssp_tx_fifo_if.sv
// Processor write port and serializer pop port of the SSP transmit FIFO.
// master = processor/serializer side, slave = the FIFO itself.
interface ssp_tx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             PSEL;
  logic             PWRITE;
  logic [WIDTH-1:0] PWDATA;
  logic             TxNextWord;
  logic [WIDTH-1:0] TxData;
  logic             TxValidWord;
  logic             TxIsEmpty;
  logic             SSPTXINTR;
  logic [AW:0]      TxCount;

  modport master (
    output PSEL, PWRITE, PWDATA, TxNextWord,
    input  TxData, TxValidWord, TxIsEmpty, SSPTXINTR, TxCount
  );

  modport slave (
    input  PSEL, PWRITE, PWDATA, TxNextWord,
    output TxData, TxValidWord, TxIsEmpty, SSPTXINTR, TxCount
  );
endinterface

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: first-word-fall-through, one push and one pop per cycle, 1-cycle write-to-read.
// Pushes while full are dropped unless a pop frees the slot that cycle; pops while empty are ignored.
module ssp_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          PCLK,
  input logic          CLEAR,
  ssp_tx_fifo_if.slave bus
);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr;
  logic             do_rd;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the write.
  always_comb begin
    do_rd = bus.TxNextWord && (cnt_q != '0);
    do_wr = bus.PSEL && bus.PWRITE && ((cnt_q != CNT_FULL) || do_rd);
    wp_d  = do_wr ? wp_q + 1'b1 : wp_q;
    rp_d  = do_rd ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wp_q] <= bus.PWDATA;
      end
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.TxData      = mem_q[rp_q];
  assign bus.TxValidWord = (cnt_q != '0);
  assign bus.TxIsEmpty   = (cnt_q == '0);
  assign bus.SSPTXINTR   = (cnt_q == CNT_FULL);
  assign bus.TxCount     = cnt_q;
endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Bench for ssp_tx_fifo: directed scenarios then random traffic against a queue-based model,
// with a scoreboard of expected popped words and per-cycle expected status.
module tb_ssp_tx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    int             cnt;
    logic [WIDTH-1:0] head;
    bit             head_chk;
  } stat_t;

  logic PCLK = 1'b0;
  logic CLEAR = 1'b1;

  ssp_tx_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  ssp_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .PCLK (PCLK),
    .CLEAR(CLEAR),
    .bus  (bus)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q [$];
  bit               data_zero = 1'b1;
  logic [WIDTH-1:0] exp_q [$];
  stat_t            stat_q [$];
  bit               done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: record the status the DUT should show now, drive, then advance the model.
  task automatic cycle(input bit sel, input bit wr, input logic [WIDTH-1:0] d,
                       input bit nxt, input bit clr);
    stat_t s;
    bit    pop_ok;
    bit    push_ok;
    s.cnt      = model_q.size();
    s.head_chk = (model_q.size() != 0) || data_zero;
    s.head     = (model_q.size() != 0) ? model_q[0] : '0;
    stat_q.push_back(s);

    bus.PSEL       = sel;
    bus.PWRITE     = wr;
    bus.PWDATA     = d;
    bus.TxNextWord = nxt;
    CLEAR          = clr;

    if (clr) begin
      model_q.delete();
      data_zero = 1'b1;
    end else begin
      pop_ok  = nxt && (model_q.size() != 0);
      push_ok = sel && wr && ((model_q.size() != DEPTH) || pop_ok);
      if (pop_ok) exp_q.push_back(model_q.pop_front());
      if (push_ok) begin
        model_q.push_back(d);
        data_zero = 1'b0;
      end
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: status every cycle, popped data whenever the serializer takes a valid word.
  initial begin
    stat_t s;
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge PCLK);
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        check("TxCount", int'(bus.TxCount), s.cnt);
        check("TxIsEmpty", int'(bus.TxIsEmpty), int'(s.cnt == 0));
        check("TxValidWord", int'(bus.TxValidWord), int'(s.cnt != 0));
        check("SSPTXINTR", int'(bus.SSPTXINTR), int'(s.cnt == DEPTH));
        if (s.head_chk) check("TxData", int'(bus.TxData), int'(s.head));
        if (bus.TxNextWord && bus.TxValidWord && !CLEAR) begin
          if (exp_q.size() == 0) begin
            check("pop_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pop_data", int'(bus.TxData), int'(e));
          end
        end
      end
    end
  end

  initial begin
    int psel_pct;
    int pop_pct;
    bus.PSEL       = 1'b0;
    bus.PWRITE     = 1'b0;
    bus.PWDATA     = '0;
    bus.TxNextWord = 1'b0;
    @(posedge PCLK);
    #1;
    CLEAR = 1'b0;

    idle();
    idle();
    push(8'hA5);
    pop();
    idle();

    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    idle();
    pop(); pop(); pop(); pop();
    idle();

    pop(); pop(); pop();
    push(8'h7E);
    pop();
    idle();

    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    cycle(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    pop(); pop(); pop(); pop();
    idle();
    cycle(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
    idle();
    pop();

    // PSEL or PWRITE alone must not push.
    cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hEF, 1'b0, 1'b0);
    idle();

    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b1, WIDTH'(i), (i % 3) != 1, 1'b0);
    end
    pop(); pop(); pop(); pop();
    idle();

    push(8'hB1); push(8'hB2); push(8'hB3);
    cycle(1'b1, 1'b1, 8'hB4, 1'b1, 1'b1);
    idle();
    pop();
    idle();

    for (int seg = 0; seg < 8; seg++) begin
      psel_pct = (seg % 2 == 0) ? 80 : 30;
      pop_pct  = (seg % 2 == 0) ? 30 : 80;
      for (int k = 0; k < 60; k++) begin
        cycle($urandom_range(99) < psel_pct + 10,
              $urandom_range(99) < 90,
              WIDTH'($urandom),
              $urandom_range(99) < pop_pct,
              $urandom_range(99) < 2);
      end
    end

    for (int k = 0; k < DEPTH + 1; k++) pop();
    idle();
    @(negedge PCLK);
    check("scoreboard_drained", exp_q.size(), 0);
    check("status_drained", stat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
